// File: rtl/key_event_ctrl_pkg.sv
// Shared definitions for the key event controller: defaults, event layout, FSM encoding.
package key_event_ctrl_pkg;

    localparam int KEY_NUM_DEF   = 20;
    localparam int EV_W          = 6;
    localparam int EV_PRESS_BIT  = 5;
    localparam int IDX_W         = 5;
    localparam int STAB_W        = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // Bit 5 = press(1)/release(0), bits 4:0 = key index.
    typedef struct packed {
        logic             press;
        logic [IDX_W-1:0] key;
    } key_event_t;

    function automatic key_event_t mk_event(input logic press, input logic [IDX_W-1:0] key);
        key_event_t ev;
        ev.press = press;
        ev.key   = key;
        return ev;
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Event FIFO: registered head, no bypass; full is judged before any same-cycle pop.
module key_event_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push, do_pop;

    assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    // Pointers wrap by natural overflow since the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/key_event_ctrl.sv
// Debounces the scanned key vector and walks each accepted snapshot, queueing
// one press/release event per changed key in ascending index order.
module key_event_ctrl
    import key_event_ctrl_pkg::*;
#(
    parameter int KEY_NUM       = KEY_NUM_DEF,
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] scan_result,
    output logic               ev_valid,
    output logic [EV_W-1:0]    ev_data,
    input  logic               ev_ready,
    output logic [KEY_NUM-1:0] key_state,
    output logic               busy
);

    logic [KEY_NUM-1:0] in_q;
    logic [STAB_W-1:0]  stab_cnt;
    logic               stable, stab_hit;

    state_t             state, state_next;
    logic [IDX_W-1:0]   idx, idx_next;
    logic [KEY_NUM-1:0] target, target_next;
    logic [KEY_NUM-1:0] key_state_next;
    logic               push, adv;
    logic               fifo_full, fifo_empty;
    key_event_t         push_ev;

    assign stable   = (scan_result == in_q);
    // Fires only on the increment that reaches the threshold, so saturation never retriggers.
    assign stab_hit = stable && (stab_cnt == STAB_W'(STABLE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q     <= '0;
            stab_cnt <= '0;
        end else begin
            in_q <= scan_result;
            if (!stable)
                stab_cnt <= '0;
            else if (stab_cnt != STAB_W'(STABLE_CYCLES))
                stab_cnt <= stab_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            target    <= '0;
            key_state <= '0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            target    <= target_next;
            key_state <= key_state_next;
        end
    end

    always_comb begin
        state_next     = state;
        idx_next       = idx;
        target_next    = target;
        key_state_next = key_state;
        push           = 1'b0;
        adv            = 1'b0;
        case (state)
            ST_IDLE: begin
                if (stab_hit) begin
                    target_next = in_q;
                    idx_next    = '0;
                    state_next  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (target[idx] != key_state[idx]) begin
                    // A full FIFO stalls the walk on this key rather than dropping the event.
                    if (!fifo_full) begin
                        push                = 1'b1;
                        key_state_next[idx] = target[idx];
                        adv                 = 1'b1;
                    end
                end else begin
                    adv = 1'b1;
                end
                if (adv) begin
                    if (idx == IDX_W'(KEY_NUM - 1)) begin
                        state_next = ST_IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign push_ev  = mk_event(target[idx], idx);
    assign busy     = (state == ST_SCAN);
    assign ev_valid = !fifo_empty;

    key_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (EV_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_ev),
        .pop       (ev_ready),
        .head      (ev_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
